// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU with valid/ready handshake, shift-add multiply and restoring divide.
// Define ALU_DIV_EN to build the iterative DIVU/REMU datapath; otherwise ops 12/13 return 0 in one cycle.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic [SHW-1:0]   cnt_q;
  logic [WIDTH-1:0] acc_q;     // product high half / partial remainder
  logic [WIDTH-1:0] lo_q;      // multiplier bits / dividend-quotient shifter
  logic [WIDTH-1:0] m_q;       // multiplicand or divisor
  logic             sel_hi_q;  // op[0]: pick acc (MULHU/REMU) over lo (MUL/DIVU)
`ifdef ALU_DIV_EN
  logic             is_div_q;
`endif

  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] simple_res;
  logic             iter_op;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] iter_acc_d;
  logic [WIDTH-1:0] iter_lo_d;
  logic [WIDTH-1:0] fin_res_d;

  assign sh = operand_b[SHW-1:0];

  always_comb begin
    simple_res = '0;
    case (op)
      4'd0: simple_res = operand_a + operand_b;
      4'd1: simple_res = operand_a - operand_b;
      4'd2: simple_res = operand_a & operand_b;
      4'd3: simple_res = operand_a | operand_b;
      4'd4: simple_res = operand_a ^ operand_b;
      4'd5: simple_res = operand_a << sh;
      4'd6: simple_res = operand_a >> sh;
      4'd7: simple_res = $unsigned($signed(operand_a) >>> sh);
      4'd8: simple_res = {{(WIDTH-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
      4'd9: simple_res = {{(WIDTH-1){1'b0}}, operand_a < operand_b};
      default: simple_res = '0;
    endcase
  end

`ifdef ALU_DIV_EN
  assign iter_op = (op == 4'd10) || (op == 4'd11) || (op == 4'd12) || (op == 4'd13);
`else
  assign iter_op = (op == 4'd10) || (op == 4'd11);
`endif

  assign mul_sum = {1'b0, acc_q} + {1'b0, (lo_q[0] ? m_q : {WIDTH{1'b0}})};

`ifdef ALU_DIV_EN
  logic [WIDTH:0] div_part;
  logic [WIDTH:0] div_diff;
  logic           div_ge;

  assign div_part = {acc_q, lo_q[WIDTH-1]};
  assign div_ge   = div_part >= {1'b0, m_q};
  assign div_diff = div_part - {1'b0, m_q};

  always_comb begin
    iter_acc_d = mul_sum[WIDTH:1];
    iter_lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
    if (is_div_q) begin
      // A zero divisor always "fits", yielding all-ones quotient and remainder = dividend.
      iter_acc_d = div_ge ? div_diff[WIDTH-1:0] : div_part[WIDTH-1:0];
      iter_lo_d  = {lo_q[WIDTH-2:0], div_ge};
    end
  end
`else
  assign iter_acc_d = mul_sum[WIDTH:1];
  assign iter_lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
`endif

  assign fin_res_d = sel_hi_q ? iter_acc_d : iter_lo_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
      cnt_q    <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      m_q      <= '0;
      sel_hi_q <= 1'b0;
`ifdef ALU_DIV_EN
      is_div_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            sel_hi_q <= op[0];
            m_q      <= op[2] ? operand_b : operand_a;
            lo_q     <= op[2] ? operand_a : operand_b;
`ifdef ALU_DIV_EN
            is_div_q <= op[2];
`endif
            if (iter_op) begin
              state_q <= BUSY;
            end else begin
              result_q <= simple_res;
              zero_q   <= (simple_res == '0);
              state_q  <= DONE;
            end
          end
        end
        BUSY: begin
          acc_q <= iter_acc_d;
          lo_q  <= iter_lo_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) begin
            result_q <= fin_res_d;
            zero_q   <= (fin_res_d == '0);
            state_q  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == BUSY);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;
endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - directed self-checking bench for alu_mc at WIDTH=32.
module tb_alu_mc;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        busy;

  int checks = 0;
  int errors = 0;

  alu_mc #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Issue one op with out_ready=1, measure latency and busy cycles, check result/zero.
  task automatic run(input string tag, input logic [3:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                     input int exp_busy);
    int lat;
    int busy_cnt;
    @(negedge clk);
    check({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    op        = o;
    operand_a = a;
    operand_b = b;
    out_ready = 1'b1;
    @(posedge clk);
    lat = 0;
    busy_cnt = 0;
    @(negedge clk);
    in_valid  = 1'b0;
    operand_a = 32'hDEAD_BEEF;
    operand_b = 32'h1234_5678;
    op        = 4'd3;
    lat = 1;
    while (!out_valid && lat < 200) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, lat, exp_lat);
    check({tag, ".result"}, result, exp);
    check({tag, ".zero"}, {31'd0, zero}, {31'd0, exp == 32'd0});
    if (exp_busy >= 0) check({tag, ".busy_cycles"}, busy_cnt, exp_busy);
  endtask

  initial begin
    int lat;
    reset     = 1'b1;
    in_valid  = 1'b0;
    op        = 4'd0;
    operand_a = '0;
    operand_b = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst.in_ready", {31'd0, in_ready}, 32'd1);
    check("rst.out_valid", {31'd0, out_valid}, 32'd0);
    check("rst.result", result, 32'd0);
    check("rst.zero", {31'd0, zero}, 32'd1);
    check("rst.busy", {31'd0, busy}, 32'd0);

    run("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 0);
    run("sub",      4'd1, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1, -1);
    run("and",      4'd2, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'h00F0_F000, 1, -1);
    run("or",       4'd3, 32'hF000_000F, 32'h0F00_00F0, 32'hFF00_00FF, 1, -1);
    run("xor",      4'd4, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1, -1);
    run("sll",      4'd5, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1, -1);
    run("srl",      4'd6, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1, -1);
    run("sra",      4'd7, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1, -1);
    run("slt",      4'd8, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1, -1);
    run("sltu",     4'd9, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, -1);
    run("rsvd14",   4'd14, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000, 1, -1);

    run("mul_ovf",  4'd10, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 33, 32);
    run("mulhu",    4'd11, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 33, 32);
    run("mul_small", 4'd10, 32'd7, 32'd6, 32'd42, 33, 32);
    run("mulhu_max", 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 32);

`ifdef ALU_DIV_EN
    run("divu",     4'd12, 32'd100, 32'd7, 32'd14, 33, 32);
    run("remu",     4'd13, 32'd100, 32'd7, 32'd2, 33, 32);
    run("divu_z",   4'd12, 32'd5, 32'd0, 32'hFFFF_FFFF, 33, 32);
    run("remu_z",   4'd13, 32'd5, 32'd0, 32'd5, 33, 32);
    run("divu_big", 4'd12, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 33, 32);
`else
    run("divu_off", 4'd12, 32'd100, 32'd7, 32'd0, 1, 0);
    run("remu_off", 4'd13, 32'd100, 32'd7, 32'd0, 1, 0);
`endif

    // Backpressure: hold result, refuse new request until the handshake completes.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    op        = 4'd0;
    operand_a = 32'd2;
    operand_b = 32'd3;
    @(posedge clk);
    @(negedge clk);
    operand_a = 32'd10;
    operand_b = 32'd10;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    for (int i = 0; i < 5; i++) begin
      check("bp.out_valid", {31'd0, out_valid}, 32'd1);
      check("bp.result", result, 32'd5);
      check("bp.zero", {31'd0, zero}, 32'd0);
      check("bp.in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp.idle_out_valid", {31'd0, out_valid}, 32'd0);
    check("bp.idle_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp.next_valid", {31'd0, out_valid}, 32'd1);
    check("bp.next_result", result, 32'd20);

    // Reset during a multiply discards the in-flight result.
    run("pre_rst_add", 4'd0, 32'd1, 32'd1, 32'd2, 1, -1);
    @(negedge clk);
    in_valid  = 1'b1;
    op        = 4'd10;
    operand_a = 32'd9;
    operand_b = 32'd9;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("mid.busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid.out_valid", {31'd0, out_valid}, 32'd0);
    check("mid.busy", {31'd0, busy}, 32'd0);
    check("mid.in_ready", {31'd0, in_ready}, 32'd1);
    run("post_rst_add", 4'd0, 32'd2, 32'd3, 32'd5, 1, 0);
    repeat (40) begin
      @(negedge clk);
      if (out_valid) check("mid.stale", {31'd0, out_valid}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
